// File: rtl/serial_compare.sv
// Bit-serial magnitude comparator: consumes two operands MSB-first, one bit pair per
// accepted beat, and reports signed/unsigned less-than and equality after WIDTH beats.
module serial_compare #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic lt,
  output logic ltu,
  output logic eq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             ult_q, ult_d;
  logic             slt_q, slt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
  logic             eq_q, eq_d;
  logic             accept_s;
  logic             differ_s;

  // Next-state and datapath: the first differing bit pair fixes both orderings.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    ult_d     = ult_q;
    slt_d     = slt_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    eq_d      = eq_q;
    accept_s  = (state_q == S_SHIFT) && bit_valid && !start;
    differ_s  = (a_bit != b_bit);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_d     = ZERO_CNT;
          decided_d = 1'b0;
          ult_d     = 1'b0;
          slt_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_d     = ZERO_CNT;
          decided_d = 1'b0;
          ult_d     = 1'b0;
          slt_d     = 1'b0;
        end else if (accept_s) begin
          cnt_d = cnt_q + ONE_CNT;
          if (!decided_q && differ_s) begin
            decided_d = 1'b1;
            ult_d     = b_bit;
            // On the sign bit the operand carrying a 1 is the negative, lesser one.
            slt_d     = (cnt_q == ZERO_CNT) ? a_bit : b_bit;
          end else begin
            decided_d = decided_q;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_d     = ZERO_CNT;
          decided_d = 1'b0;
          ult_d     = 1'b0;
          slt_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = ZERO_CNT;
        decided_d = 1'b0;
        ult_d     = 1'b0;
        slt_d     = 1'b0;
      end
    endcase

    // DONE never loops on itself, so state_d == S_DONE marks the entry edge.
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      lt_d   = slt_d;
      ltu_d  = ult_d;
      eq_d   = ~decided_d;
    end else begin
      done_d = 1'b0;
    end

    busy_d = (state_d == S_SHIFT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= ZERO_CNT;
      decided_q <= 1'b0;
      ult_q     <= 1'b0;
      slt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      ult_q     <= ult_d;
      slt_q     <= slt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      eq_q      <= eq_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign ltu  = ltu_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed and exhaustive bench for serial_compare; expected results queue up when an
// operation is launched and are popped when done is observed.
module tb_serial_compare;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, a_bit, b_bit;
  logic busy, done, lt, ltu, eq;

  typedef struct packed {
    logic lt;
    logic ltu;
    logic eq;
  } res_t;

  res_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  serial_compare #(.WIDTH(6), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .lt(lt), .ltu(ltu), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // mode 0: bit_valid always high; 1: pattern 1,0,0 repeating; 2: random gaps
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input int mode, input string tag);
    res_t e;
    res_t r;
    int   acc;
    int   cyc;
    bit   got;
    bit   v;
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    e.eq  = (a == b);
    exp_q.push_back(e);

    start = 1'b1; bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);

    acc = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 3) == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (v && acc < 6) begin
        bit_valid = 1'b1; a_bit = a[5-acc]; b_bit = b[5-acc];
      end else begin
        bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (bit_valid) acc++;
      if (done) got = 1'b1;
    end
    bit_valid = 1'b0;

    check({tag, " done_seen"}, got, 1);
    check({tag, " beats_at_done"}, acc, 6);
    if (mode == 0) check({tag, " latency"}, cyc, 6);

    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check({tag, " lt"}, lt, r.lt);
      check({tag, " ltu"}, ltu, r.ltu);
      check({tag, " eq"}, eq, r.eq);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " busy_after_done"}, busy, 0);
      check({tag, " held_result"}, {lt, ltu, eq}, {r.lt, r.ltu, r.eq});
    end else begin
      check({tag, " scoreboard_empty"}, exp_q.size(), 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset outs", {lt, ltu, eq}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // bit_valid while idle must not disturb anything
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle ignore busy", busy, 0);
    check("idle ignore done", done, 0);
    bit_valid = 1'b0;

    run_op(6'b000101, 6'b111101, 0, "a5_b61");
    run_op(6'b100000, 6'b011111, 0, "neg32_31");
    run_op(6'd42, 6'd42, 0, "eq42");
    run_op(6'd3, 6'd4, 1, "stall_3_4");
    run_op(6'd3, 6'd4, 0, "nostall_3_4");

    // Abort: three beats of 60 vs 2, then a restart that must produce the only done
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = 6'd60 >> (5 - i); b_bit = 6'd2 >> (5 - i);
      @(posedge clk); #1;
      check("abort no_done", done, 0);
    end
    run_op(6'd7, 6'd7, 0, "abort_restart_7_7");

    // Reset mid-operation clears outputs without waiting for a clock edge
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset outs", {lt, ltu, eq}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset no_done", done, 0);
    run_op(6'd1, 6'd0, 0, "after_reset_1_0");

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        run_op(6'(a), 6'(b), 2, $sformatf("exh a=%0d b=%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
